// File: rtl/register_file_sb.sv
// Integer register file with a pending-write scoreboard and writeback-to-read
// forwarding, so issue can detect RAW hazards directly from the read ports.
module register_file_sb #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [XLEN-1:0]             register_file_data,
  input  logic [$clog2(NUM_REGS)-1:0] rd,
  input  logic [$clog2(NUM_REGS)-1:0] rs1_address,
  input  logic [$clog2(NUM_REGS)-1:0] rs2_address,
  output logic [XLEN-1:0]             rs1_data,
  output logic [XLEN-1:0]             rs2_data,
  output logic                        rs1_valid,
  output logic                        rs2_valid,
  input  logic                        reserve,
  input  logic [$clog2(NUM_REGS)-1:0] reserve_rd,
  output logic [NUM_REGS-1:0]         pending
);

  localparam int AW = $clog2(NUM_REGS);
  localparam bit HARD_ZERO = (ZERO_REG != 0);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                wr_ok;

  assign wr_ok = en && !(HARD_ZERO && (rd == '0));

  // A reservation landing on the same edge as a writeback wins: the new producer owns the register.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reserve && (reserve_rd == AW'(i)) && !(HARD_ZERO && (i == 0))) begin
        pending_d[i] = 1'b1;
      end else if (en && (rd == AW'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      if (wr_ok) begin
        regs_q[rd] <= register_file_data;
      end
    end
  end

  assign pending = pending_q;

  // Read priority: hardwired zero, then writeback bypass, then array with scoreboard.
  always_comb begin
    rs1_data  = regs_q[rs1_address];
    rs1_valid = ~pending_q[rs1_address];
    if (HARD_ZERO && (rs1_address == '0)) begin
      rs1_data  = '0;
      rs1_valid = 1'b1;
    end else if (en && (rd == rs1_address)) begin
      rs1_data  = register_file_data;
      rs1_valid = 1'b1;
    end
  end

  always_comb begin
    rs2_data  = regs_q[rs2_address];
    rs2_valid = ~pending_q[rs2_address];
    if (HARD_ZERO && (rs2_address == '0)) begin
      rs2_data  = '0;
      rs2_valid = 1'b1;
    end else if (en && (rd == rs2_address)) begin
      rs2_data  = register_file_data;
      rs2_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: reset, write/read, x0, bypass,
// scoreboard reserve/release, simultaneous events and asynchronous reset.
module tb_register_file_sb;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int AW       = $clog2(NUM_REGS);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [XLEN-1:0]     register_file_data;
  logic [AW-1:0]       rd;
  logic [AW-1:0]       rs1_address;
  logic [AW-1:0]       rs2_address;
  logic [XLEN-1:0]     rs1_data;
  logic [XLEN-1:0]     rs2_data;
  logic                rs1_valid;
  logic                rs2_valid;
  logic                reserve;
  logic [AW-1:0]       reserve_rd;
  logic [NUM_REGS-1:0] pending;

  int tests  = 0;
  int failed = 0;

  register_file_sb #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .ZERO_REG(1)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .en                 (en),
    .register_file_data (register_file_data),
    .rd                 (rd),
    .rs1_address        (rs1_address),
    .rs2_address        (rs2_address),
    .rs1_data           (rs1_data),
    .rs2_data           (rs2_data),
    .rs1_valid          (rs1_valid),
    .rs2_valid          (rs2_valid),
    .reserve            (reserve),
    .reserve_rd         (reserve_rd),
    .pending            (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; rd = 5'd5; register_file_data = 32'hDEADBEEF;
    reserve = 1'b1; reserve_rd = 5'd5; rs1_address = 5'd1; rs2_address = 5'd2;
    tick();

    // Reset: writes and reservations ignored
    en = 1'b0; reserve = 1'b0; rs1_address = 5'd5; rs2_address = 5'd5;
    #1;
    check("rst_reg5_data", 64'(rs1_data), 64'h0);
    check("rst_rs1_valid", 64'(rs1_valid), 64'h1);
    check("rst_rs2_valid", 64'(rs2_valid), 64'h1);
    check("rst_pending", 64'(pending), 64'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_reg5", 64'(rs2_data), 64'h0);

    // Write x7 and x31, read both next cycle
    en = 1'b1; rd = 5'd7; register_file_data = 32'h12345678;
    tick();
    rd = 5'd31; register_file_data = 32'hCAFEF00D;
    tick();
    en = 1'b0; rs1_address = 5'd7; rs2_address = 5'd31;
    #1;
    check("rd_x7_data", 64'(rs1_data), 64'h12345678);
    check("rd_x31_data", 64'(rs2_data), 64'hCAFEF00D);
    check("rd_x7_valid", 64'(rs1_valid), 64'h1);
    check("rd_x31_valid", 64'(rs2_valid), 64'h1);

    // x0 write dropped, reads zero in same and next cycle
    en = 1'b1; rd = 5'd0; register_file_data = 32'hFFFFFFFF; rs1_address = 5'd0;
    #1;
    check("x0_same_cycle", 64'(rs1_data), 64'h0);
    check("x0_valid", 64'(rs1_valid), 64'h1);
    tick();
    en = 1'b0;
    #1;
    check("x0_next_cycle", 64'(rs1_data), 64'h0);

    // Same-cycle bypass on both ports
    en = 1'b1; rd = 5'd3; register_file_data = 32'hA5A5A5A5;
    rs1_address = 5'd3; rs2_address = 5'd3;
    #1;
    check("bypass_rs2_data", 64'(rs2_data), 64'hA5A5A5A5);
    check("bypass_rs2_valid", 64'(rs2_valid), 64'h1);
    check("bypass_rs1_data", 64'(rs1_data), 64'hA5A5A5A5);
    tick();
    en = 1'b0; register_file_data = 32'h0;
    #1;
    check("x3_from_array", 64'(rs2_data), 64'hA5A5A5A5);

    // Scoreboard: reserve x9, then release via writeback
    reserve = 1'b1; reserve_rd = 5'd9; rs1_address = 5'd9;
    #1;
    check("rsv_same_cycle_valid", 64'(rs1_valid), 64'h1);
    tick();
    reserve = 1'b0;
    #1;
    check("rsv_x9_valid", 64'(rs1_valid), 64'h0);
    check("rsv_x9_pending", 64'(pending), 64'h200);
    en = 1'b1; rd = 5'd9; register_file_data = 32'h55;
    #1;
    check("release_bypass_valid", 64'(rs1_valid), 64'h1);
    check("release_bypass_data", 64'(rs1_data), 64'h55);
    check("release_pending_before_edge", 64'(pending), 64'h200);
    tick();
    en = 1'b0;
    #1;
    check("release_pending_after", 64'(pending), 64'h0);
    check("release_x9_data", 64'(rs1_data), 64'h55);
    check("release_x9_valid", 64'(rs1_valid), 64'h1);

    // Reserve and write x4 on the same edge: set wins, data updates
    reserve = 1'b1; reserve_rd = 5'd4; en = 1'b1; rd = 5'd4; register_file_data = 32'h00004444;
    tick();
    reserve = 1'b0; en = 1'b0; rs1_address = 5'd4;
    #1;
    check("simul_pending4", 64'(pending), 64'h10);
    check("simul_x4_data", 64'(rs1_data), 64'h4444);
    check("simul_x4_valid", 64'(rs1_valid), 64'h0);

    // Reserve of x0 ignored; write to non-pending x10 leaves scoreboard alone
    reserve = 1'b1; reserve_rd = 5'd0; en = 1'b1; rd = 5'd10; register_file_data = 32'h1010;
    tick();
    reserve = 1'b0; en = 1'b0; rs2_address = 5'd10;
    #1;
    check("rsv_x0_pending", 64'(pending), 64'h10);
    check("nonpending_x10_data", 64'(rs2_data), 64'h1010);
    check("nonpending_x10_valid", 64'(rs2_valid), 64'h1);

    // Populate x2/x6, reserve both, then async reset between edges
    en = 1'b1; rd = 5'd2; register_file_data = 32'h22;
    tick();
    rd = 5'd6; register_file_data = 32'h66;
    reserve = 1'b1; reserve_rd = 5'd2;
    tick();
    en = 1'b0; reserve_rd = 5'd6;
    tick();
    reserve = 1'b0; rs1_address = 5'd2; rs2_address = 5'd6;
    #1;
    check("pre_rst_pending", 64'(pending), 64'h54);
    check("pre_rst_x6_data", 64'(rs2_data), 64'h66);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_pending", 64'(pending), 64'h0);
    check("arst_x2_data", 64'(rs1_data), 64'h0);
    check("arst_x6_data", 64'(rs2_data), 64'h0);
    check("arst_x2_valid", 64'(rs1_valid), 64'h1);
    check("arst_x6_valid", 64'(rs2_valid), 64'h1);
    rs1_address = 5'd7;
    #1;
    check("arst_x7_data", 64'(rs1_data), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
